// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the first set request at or after ptr, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] next_winner(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder that forms the grant lines from the winner index.
module decoder3to8
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter over 8 requesters with hold-while-requested grants and
// a MAX_HOLD forced release; the grant is the decode of the registered index.
module rr_decoder_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [N_REQ-1:0] dec;

    decoder3to8 u_dec (
        .idx    (gnt_idx),
        .onehot (dec)
    );

    // Gating by the registered valid keeps gnt at zero through the dead cycle
    // and clears it immediately on an asynchronous reset.
    assign gnt = dec & {N_REQ{gnt_valid}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = next_winner(req, ptr);
                    valid_nxt = 1'b1;
                    hold_nxt  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (req[gnt_idx] && hold_cnt < HOLD_LIMIT) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end else begin
                    // Voluntary drop or forced revoke: the grantee moves to the back.
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx + IDX_W'(1);
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    hold_nxt    = '0;
                    timeout_nxt = req[gnt_idx];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid ? $onehot(gnt) : (gnt == '0));

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: two instances (MAX_HOLD 16 and 4) are
// checked every cycle against a behavioural model plus literal expectations.
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_o   [2];
    logic [2:0] idx_o   [2];
    logic       valid_o [2];
    logic       to_o    [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    localparam int MAXH [2] = '{16, 4};

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.MAX_HOLD(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_o[0]), .gnt_idx(idx_o[0]), .gnt_valid(valid_o[0]), .timeout(to_o[0])
    );

    rr_decoder_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_o[1]), .gnt_idx(idx_o[1]), .gnt_valid(valid_o[1]), .timeout(to_o[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner = -1 when nobody holds the resource; held = cycles owned so far.
    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    bit m_to    [2];

    always @(posedge clk or negedge rst_n) begin : model
        int own, held, p;
        bit t;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_owner[i] <= -1;
                m_held[i]  <= 0;
                m_ptr[i]   <= 0;
                m_to[i]    <= 1'b0;
            end else begin
                own = m_owner[i]; held = m_held[i]; p = m_ptr[i]; t = 1'b0;
                if (own < 0) begin
                    for (int k = 0; k < 8; k++) begin
                        if (own < 0 && req[(p + k) % 8]) own = (p + k) % 8;
                    end
                    if (own >= 0) held = 1;
                end else if (req[own] && held < MAXH[i]) begin
                    held = held + 1;
                end else begin
                    t    = req[own];
                    p    = (own + 1) % 8;
                    own  = -1;
                    held = 0;
                end
                m_owner[i] <= own;
                m_held[i]  <= held;
                m_ptr[i]   <= p;
                m_to[i]    <= t;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_gnt[%0d]", i), gnt_o[i],
                      (m_owner[i] < 0) ? 0 : (1 << m_owner[i]));
                check($sformatf("model_idx[%0d]", i), idx_o[i],
                      (m_owner[i] < 0) ? 0 : m_owner[i]);
                check($sformatf("model_valid[%0d]", i), valid_o[i], m_owner[i] >= 0);
                check($sformatf("model_timeout[%0d]", i), to_o[i], m_to[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int got;
        bit seen;
        #1 rst_n = 1'b0;
        step();
        check("reset_gnt", gnt_o[0], 8'h00);
        check("reset_valid", valid_o[0], 0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset / idle
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_gnt", gnt_o[0], 8'h00);
            check("idle_timeout", to_o[0], 0);
        end
        check("idle_idx", idx_o[0], 0);

        // Single requester, then probe the rotated pointer with bits 2 and 4
        req = 8'h04;
        step();
        check("single_gnt", gnt_o[0], 8'h04);
        check("single_idx", idx_o[0], 2);
        repeat (4) step();
        req = 8'h00;
        step();
        check("single_release", gnt_o[0], 8'h00);
        req = 8'h14;
        step();
        check("ptr_after_release", idx_o[0], 4);
        req = 8'h00;
        repeat (3) step();

        // Rotation with wrap: each grantee drops after 2 cycles, then re-raises
        do_reset();
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            seen = 1'b0;
            for (int w = 0; w < 20 && !seen; w++) begin
                step();
                seen = valid_o[0];
            end
            if (!seen) begin
                failures++;
                $display("FAIL rotate_wait: no grant within 20 cycles for round %0d", n);
            end
            got = idx_o[0];
            check($sformatf("rotate_order[%0d]", n), got, n % 8);
            step();
            req[got] = 1'b0;
            step();
            check("rotate_dead_cycle", valid_o[0], 0);
            req[got] = 1'b1;
        end
        req = 8'h00;
        repeat (3) step();

        // Timeout on the MAX_HOLD=4 instance
        do_reset();
        req = 8'h80;
        for (int k = 0; k < 4; k++) begin
            step();
            check("timeout_hold_gnt", gnt_o[1], 8'h80);
            check("timeout_hold_pulse", to_o[1], 0);
        end
        step();
        check("timeout_release_gnt", gnt_o[1], 8'h00);
        check("timeout_pulse", to_o[1], 1);
        step();
        check("timeout_regrant", gnt_o[1], 8'h80);
        check("timeout_pulse_end", to_o[1], 0);
        req = 8'h00;
        repeat (3) step();

        // Priority after release: 5 drops, then 0 and 5 both request
        do_reset();
        req = 8'h20;
        step();
        check("prio_first", idx_o[0], 5);
        req = 8'h01;
        step();
        check("prio_dead", gnt_o[0], 8'h00);
        req = 8'h21;
        step();
        check("prio_next", gnt_o[0], 8'h01);
        req = 8'h00;
        repeat (3) step();

        // Asynchronous reset mid-grant
        do_reset();
        req = 8'h08;
        step();
        check("areset_pre", gnt_o[0], 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("areset_gnt", gnt_o[0], 8'h00);
        check("areset_valid", valid_o[0], 0);
        check("areset_idx", idx_o[0], 0);
        req = 8'h09;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("areset_restart", gnt_o[0], 8'h01);
        req = 8'h00;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- 8-way round-robin arbiter that shares one decoded resource among 8 requesters.
- Selects one requester, holds the grant while that requester keeps its request asserted, then rotates priority.
- The winner index (3 bits) drives a 3-to-8 decoder to form the one-hot grant, so the select bus and grant lines stay consistent by construction.
- Sits between requesting agents and any shared resource addressed by a 3-bit select.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held before it is forcibly revoked; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i is requester i; level-sensitive.
- gnt  output  8  one-hot grant; all zeros when no grant is held.
- gnt_idx  output  3  index of the current grantee; 0 when idle.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE.
- All outputs are registered. gnt is the decode of gnt_idx gated by gnt_valid.
- State IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next cycle: state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=1.
  - Latency: req sampled at edge t produces gnt visible after edge t.
- State GRANT:
  - If req[gnt_idx]=1 and hold_cnt < MAX_HOLD, stay and increment hold_cnt.
  - If req[gnt_idx]=0, release. Next cycle: gnt_valid=0, gnt=0, ptr=gnt_idx+1 mod 8 (7 wraps to 0), state=IDLE.
  - If req[gnt_idx]=1 and hold_cnt == MAX_HOLD, force release exactly as above and pulse timeout for one cycle in the release cycle.
- Re-arbitration always passes through one IDLE cycle with gnt=0 (dead cycle). Back-to-back grants to different requesters are therefore separated by exactly one cycle.
- Requests from non-granted bits during GRANT are ignored and not latched. A requester must hold req to be considered.
- Simultaneous release and new requests: release wins that cycle; the new requests are arbitrated in the following IDLE cycle using the updated ptr.
- A requester that is released or timed out gets lowest priority next round. It may re-request immediately.
- Reset asserted mid-grant: all outputs clear asynchronously; after deassertion, arbitration restarts with ptr=0.
- Exactly one bit of gnt is set when gnt_valid=1; gnt==0 when gnt_valid=0 (checked by assertion).
- Target: 150-250 lines of RTL including the decoder.

Decomposition:
- Package rr_arb_pkg:
  - N_REQ=8, IDX_W=3.
  - State enum {IDLE, GRANT}.
  - Function next_winner(req, ptr) returning the index of the first set bit at or after ptr.
- Sub-module decoder3to8: maps gnt_idx to the one-hot gnt, ANDed with gnt_valid in the parent.
- Priority rotation, hold counter and FSM live in the top module.

Test Plan:
- Reset/idle: rst_n=0, then req=8'h00 for 10 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- Single requester: req=8'h04 held 5 cycles, then dropped -> gnt=8'h04, gnt_idx=2 one cycle after req; gnt=0 one cycle after drop; ptr becomes 3.
- Rotation with wrap: req=8'hFF held, each grantee drops its bit after 2 cycles then re-raises it -> grant order 0,1,...,7,0, with one dead cycle between grants.
- Timeout: MAX_HOLD=4, req=8'h80 held continuously -> gnt=8'h80 for 4 cycles, then gnt=0 with a timeout pulse of 1 cycle; next grant to bit 7 arrives after the dead cycle, since ptr=0 and no other requests are present.
- Priority after release: grantee 5 releases while req=8'h21 -> next grant goes to 0 (scan 6,7,0), not 5.
- Async reset mid-grant: rst_n pulsed low between clock edges during a grant to 3 -> gnt=0 immediately without waiting for a clock edge; after release with req=8'h09, first grant goes to 0.
